i2c_write_master: RTL and testbench

Single-transaction I2C write master. It drives a 7-bit slave address (write bit 0) followed by two data bytes onto an open-drain SCL/SDA pair. The block is the consumer end of the start/busy handshake used by the HDMI transmitter configuration sequencer. It sits between that sequencer and the board-level I2C pads.

---
 rtl/i2c_write_master.sv | 96 +++++++++
 tb/tb_i2c_write_master.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_write_master.sv
// i2c_write_master: single-frame I2C write (addr+W, two data bytes) on open-drain SCL/SDA.
// Define I2C_ACK_CHECK_EN to flag a NACK in ack_error and cut the frame short to STOP.
module i2c_write_master #(
  parameter int CLK_DIV = 125
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [6:0] address,
  input  logic [7:0] data_0,
  input  logic [7:0] data_1,
  input  logic       sda_i,
  output logic       busy,
  output logic       done,
  output logic       ack_error,
  output logic       scl_o,
  output logic       sda_oe
);
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  typedef enum logic [1:0] {IDLE, START, BITS, STOP} state_t;
  state_t      st_q, st_d;
  logic [DW-1:0] div_q, div_d;
  logic [1:0]  q_q, q_d;
  logic [4:0]  slot_q, slot_d;
  logic [26:0] sh_q, sh_d;
  logic        ack_err_q, ack_err_d;
  logic        scl_d, oe_d, busy_d, done_d, tick;
`ifdef I2C_ACK_CHECK_EN
  logic        ack_slot;
  assign ack_slot = slot_q == 5'd8 || slot_q == 5'd17 || slot_q == 5'd26;
  assign ack_err_d = (st_q == IDLE && start) ? 1'b0 :
                     ack_err_q | (st_q == BITS && tick && q_q == 2'd2 && ack_slot && sda_i);
`else
  logic        unused_sda;
  assign unused_sda = sda_i;
  assign ack_err_d = 1'b0;
`endif
  always_comb begin
    tick = div_q == DW'(CLK_DIV - 1);
    st_d = st_q;
    q_d = q_q;
    slot_d = slot_q;
    sh_d = sh_q;
    div_d = (st_q == IDLE || tick) ? '0 : div_q + 1'b1;
    if (st_q == IDLE) begin
      if (start) begin
        st_d = START;
        q_d = '0;
        slot_d = '0;
        sh_d = {address, 1'b0, 1'b1, data_0, 1'b1, data_1, 1'b1};
      end
    end else if (tick) begin
      q_d = q_q + 2'd1;
      if (q_q == 2'd3) begin
        if (st_q == START) st_d = BITS;
        else if (st_q == STOP) st_d = IDLE;
        else if (slot_q == 5'd26 || ack_err_q) st_d = STOP;
        else begin
          slot_d = slot_q + 5'd1;
          sh_d = {sh_q[25:0], 1'b0};
        end
      end
    end
    // Outputs are computed for the quarter being entered so they change on the quarter boundary.
    scl_d = st_d == START ? q_d != 2'd3 : st_d == BITS ? q_d[1] : st_d == STOP ? q_d != 2'd0 : 1'b1;
    oe_d = st_d == START ? q_d != 2'd0 : st_d == BITS ? ~sh_d[26] : st_d == STOP ? ~q_d[1] : 1'b0;
    busy_d = st_d != IDLE;
    done_d = st_q == STOP && tick && q_q == 2'd3;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q <= IDLE;
      div_q <= '0;
      q_q <= '0;
      slot_q <= '0;
      sh_q <= '0;
      ack_err_q <= 1'b0;
      scl_o <= 1'b1;
      sda_oe <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      st_q <= st_d;
      div_q <= div_d;
      q_q <= q_d;
      slot_q <= slot_d;
      sh_q <= sh_d;
      ack_err_q <= ack_err_d;
      scl_o <= scl_d;
      sda_oe <= oe_d;
      busy <= busy_d;
      done <= done_d;
    end
  end
  assign ack_error = ack_err_q;
endmodule

// File: tb/tb_i2c_write_master.sv
// tb_i2c_write_master: random and directed frames checked by a bus-level decoder and slave model.
module tb_i2c_write_master;
  localparam int CD = 4;
  localparam int FULL = 116 * CD;
  localparam int NACKLEN = 44 * CD;
  logic clk = 0, rst_n = 0, start = 0;
  logic [6:0] address = '0;
  logic [7:0] data_0 = '0, data_1 = '0;
  logic sda_i, busy, done, ack_error, scl_o, sda_oe;
  logic pull = 0, nack_addr = 0;
  int checks = 0, errors = 0;
  int done_cnt = 0, idle_bad = 0, glitch = 0;
  int busy_run = 0, idle_run = 0, nb = 0;
  logic ps = 1, pd = 1, pbusy = 0, in_frame = 0, hi_seen = 0;
  logic [26:0] fb = '0;
  logic [26:0] frq[$];
  int fnq[$], bl_q[$], gap_q[$];

  i2c_write_master #(.CLK_DIV(CD)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .address(address), .data_0(data_0),
    .data_1(data_1), .sda_i(sda_i), .busy(busy), .done(done), .ack_error(ack_error),
    .scl_o(scl_o), .sda_oe(sda_oe)
  );

  assign sda_i = ~sda_oe & ~pull;
  always #5 clk = ~clk;

  // Bus decoder and ACKing slave: bits are taken from the master's SDA while SCL is high.
  always @(negedge clk) begin
    logic s, d;
    s = scl_o;
    d = ~sda_oe;
    if (!rst_n) begin
      in_frame = 0; hi_seen = 0; nb = 0; pull = 0; busy_run = 0; idle_run = 0;
    end else begin
      if (busy) begin
        if (!pbusy) gap_q.push_back(idle_run);
        busy_run++; idle_run = 0;
      end else begin
        if (pbusy) bl_q.push_back(busy_run);
        busy_run = 0; idle_run++;
        if (!scl_o || sda_oe) idle_bad++;
      end
      if (done) done_cnt++;
      if (ps && s && pd && !d) begin
        if (in_frame) glitch++;
        in_frame = 1; hi_seen = 0; nb = 0; fb = '0;
      end else if (ps && s && !pd && d) begin
        if (in_frame) begin frq.push_back(fb); fnq.push_back(nb); end
        else glitch++;
        in_frame = 0; pull = 0;
      end else if (!ps && s && in_frame) hi_seen = 1;
      else if (ps && !s && in_frame) begin
        if (hi_seen) begin fb = {fb[25:0], pd}; nb++; end
        hi_seen = 0;
        pull = (nb % 9 == 8) && !(nack_addr && nb == 8);
      end
    end
    ps = s; pd = d; pbusy = busy;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [6:0] a, input logic [7:0] b0, input logic [7:0] b1);
    @(negedge clk);
    address = a; data_0 = b0; data_1 = b1; start = 1;
    @(negedge clk);
    start = 0; address = 7'($urandom); data_0 = 8'($urandom); data_1 = 8'($urandom);
  endtask

  task automatic wait_done(output bit ok);
    ok = 0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge clk);
      if (done) ok = 1;
    end
  endtask

  task automatic check_frame(input logic [6:0] a, input logic [7:0] b0, input logic [7:0] b1, input int nbits);
    logic [26:0] f;
    int n;
    if (frq.size() == 0) chk("frame_present", 0, 1);
    else begin
      f = frq.pop_front();
      n = fnq.pop_front();
      chk("nbits", n, nbits);
      if (nbits == 27) begin
        chk("byte_addr", f[26:19], {a, 1'b0});
        chk("byte_d0", f[17:10], b0);
        chk("byte_d1", f[8:1], b1);
        chk("ack_release", {f[18], f[9], f[0]}, 3'b111);
      end else chk("byte_addr", f[8:1], {a, 1'b0});
    end
  endtask

  task automatic check_len(input int exp);
    if (bl_q.size() == 0) chk("busy_present", 0, 1);
    else chk("busy_len", bl_q.pop_front(), exp);
  endtask

  task automatic do_txn(input logic [6:0] a, input logic [7:0] b0, input logic [7:0] b1,
                        input logic nack, input int inject, input int exp_len, input int nbits,
                        input logic exp_ack);
    int d0c;
    bit ok;
    frq.delete(); fnq.delete(); bl_q.delete();
    nack_addr = nack;
    d0c = done_cnt;
    send(a, b0, b1);
    chk("busy_rise", busy, 1);
    chk("ack_clear", ack_error, 0);
    if (inject > 0) begin
      repeat (inject) @(negedge clk);
      address = ~a; data_0 = ~b0; data_1 = ~b1; start = 1;
      @(negedge clk);
      start = 0;
    end
    wait_done(ok);
    chk("done_seen", ok, 1);
    repeat (3) @(negedge clk);
    chk("done_cnt", done_cnt - d0c, 1);
    chk("frame_cnt", frq.size(), 1);
    check_frame(a, b0, b1, nbits);
    check_len(exp_len);
    chk("ack_error", ack_error, exp_ack);
    chk("idle_after", busy, 0);
    nack_addr = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    logic [6:0] sa[3];
    logic [7:0] sb0[3], sb1[3];
    int k, cyc, d0c;
    bit ok;
    repeat (3) @(negedge clk);
    chk("rst_scl", scl_o, 1);
    chk("rst_sda_oe", sda_oe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ack", ack_error, 0);
    rst_n = 1;
    repeat (100) @(negedge clk);
    chk("idle_bus", idle_bad, 0);
    chk("idle_done", done_cnt, 0);
    chk("idle_busy", busy, 0);

    do_txn(7'h39, 8'h98, 8'h03, 0, 0, FULL, 27, 0);
    do_txn(7'h50, 8'h11, 8'hEE, 0, 50, FULL, 27, 0);
    for (int i = 0; i < 6; i++)
      do_txn(7'($urandom), 8'($urandom), 8'($urandom), 0, 0, FULL, 27, 0);
    do_txn(7'h7F, 8'hFF, 8'h00, 0, 0, FULL, 27, 0);
    do_txn(7'h00, 8'h00, 8'hFF, 0, 0, FULL, 27, 0);

    // Requester holds start high across three back-to-back entries.
    frq.delete(); fnq.delete(); bl_q.delete(); gap_q.delete();
    for (int i = 0; i < 3; i++) begin
      sa[i] = 7'($urandom); sb0[i] = 8'($urandom); sb1[i] = 8'($urandom);
    end
    d0c = done_cnt;
    @(negedge clk);
    address = sa[0]; data_0 = sb0[0]; data_1 = sb1[0]; start = 1;
    k = 0; cyc = 0;
    while (k < 3 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        k++;
        if (k < 3) begin address = sa[k]; data_0 = sb0[k]; data_1 = sb1[k]; end
        else start = 0;
      end
    end
    start = 0;
    chk("hold_progress", k, 3);
    repeat (5) @(negedge clk);
    chk("hold_done", done_cnt - d0c, 3);
    chk("hold_frames", frq.size(), 3);
    for (int i = 0; i < 3; i++) begin
      check_frame(sa[i], sb0[i], sb1[i], 27);
      check_len(FULL);
    end
    chk("hold_rises", gap_q.size(), 3);
    if (gap_q.size() >= 3) begin
      chk("hold_gap1", gap_q[1], 1);
      chk("hold_gap2", gap_q[2], 1);
    end

`ifdef I2C_ACK_CHECK_EN
    do_txn(7'h2A, 8'h55, 8'hAA, 1, 0, NACKLEN, 9, 1);
`else
    do_txn(7'h2A, 8'h55, 8'hAA, 1, 0, FULL, 27, 0);
`endif
    do_txn(7'h39, 8'h98, 8'h03, 0, 0, FULL, 27, 0);

    // Asynchronous reset in the middle of a frame.
    send(7'h21, 8'h42, 8'h84);
    repeat (200) @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("arst_scl", scl_o, 1);
    chk("arst_sda_oe", sda_oe, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    repeat (2) @(negedge clk);
    do_txn(7'h5A, 8'hC3, 8'h3C, 0, 0, FULL, 27, 0);

    chk("bus_glitch", glitch, 0);
    chk("idle_bus_final", idle_bad, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
